// File: rtl/shifter_op_ctrl.sv
// ARM data-processing operand-2 sequencer: rotate-immediate, immediate-shift and
// register-shift forms, with an Rs register-file fetch of configurable latency.
module shifter_op_ctrl #(
    parameter int RF_ADDR_W   = 4,
    parameter int RS_READ_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 i_bit,
    input  logic                 reg_shift,
    input  logic [1:0]           shift_type,
    input  logic [4:0]           shift_imm,
    input  logic [3:0]           rotate_imm,
    input  logic [7:0]           imm8,
    input  logic [RF_ADDR_W-1:0] rs_idx,
    input  logic [31:0]          rm_val,
    input  logic                 c_in,
    output logic [RF_ADDR_W-1:0] rs_addr,
    output logic                 rs_rd_en,
    input  logic [31:0]          rs_data,
    output logic [1:0]           shifter_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          shifter_operand,
    output logic                 shifter_carry
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RS_WAIT = 2'b01,
        SHIFT   = 2'b10,
        DONE    = 2'b11
    } state_t;

    localparam logic [1:0] SEL_ROT  = 2'b00;
    localparam logic [1:0] SEL_IMM  = 2'b01;
    localparam logic [1:0] SEL_REG  = 2'b10;
    localparam logic [1:0] LAT_INIT = 2'(RS_READ_LAT);

    // Shift by an effective amount k; returns {carry, result}. ROR uses only k[4:0].
    function automatic logic [32:0] barrel(input logic [1:0] st, input logic [7:0] k,
                                           input logic rrx, input logic [31:0] rm,
                                           input logic c);
        logic [32:0]        ext;
        logic signed [32:0] sx;
        logic [63:0]        dbl;
        logic [31:0]        res;
        logic               cy;
        ext = 33'd0;
        sx  = 33'sd0;
        dbl = 64'd0;
        res = rm;
        cy  = c;
        if (rrx) begin
            res = {c, rm[31:1]};
            cy  = rm[0];
        end else if (k == 8'd0) begin
            res = rm;
            cy  = c;
        end else begin
            case (st)
                2'b00: begin
                    ext = {1'b0, rm} << k;
                    res = ext[31:0];
                    cy  = ext[32];
                end
                2'b01: begin
                    ext = {rm, 1'b0} >> k;
                    res = ext[32:1];
                    cy  = ext[0];
                end
                2'b10: begin
                    sx  = {rm, 1'b0};
                    sx  = sx >>> k;
                    res = sx[32:1];
                    cy  = sx[0];
                end
                default: begin
                    dbl = {rm, rm} >> k[4:0];
                    res = dbl[31:0];
                    cy  = res[31];
                end
            endcase
        end
        return {cy, res};
    endfunction

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [1:0]             sel_q, sel_d;
    logic [1:0]             st_q, st_d;
    logic [4:0]             shimm_q, shimm_d;
    logic [3:0]             rot_q, rot_d;
    logic [7:0]             imm8_q, imm8_d;
    logic [31:0]            rm_q, rm_d;
    logic                   c_q, c_d;
    logic [7:0]             amt_q, amt_d;
    logic [RF_ADDR_W-1:0]   rs_addr_q, rs_addr_d;
    logic                   rd_en_q, rd_en_d;
    logic                   req_ready_q, req_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [31:0]            op_q, op_d;
    logic                   carry_q, carry_d;
    logic [32:0]            res_s;
    logic [7:0]             imm_amt_s;
    logic                   imm_rrx_s;
    logic                   unused_rs_hi;

    // Immediate shift of zero encodes 32 for LSR/ASR and RRX for ROR.
    assign imm_amt_s    = ((shimm_q == 5'd0) && (st_q != 2'b00)) ? 8'd32 : {3'b000, shimm_q};
    assign imm_rrx_s    = (shimm_q == 5'd0) && (st_q == 2'b11);
    assign unused_rs_hi = ^rs_data[31:8];

    // Next-state, request capture and result computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        st_d      = st_q;
        shimm_d   = shimm_q;
        rot_d     = rot_q;
        imm8_d    = imm8_q;
        rm_d      = rm_q;
        c_d       = c_q;
        amt_d     = amt_q;
        rs_addr_d = rs_addr_q;
        rd_en_d   = 1'b0;
        op_d      = op_q;
        carry_d   = carry_q;
        res_s     = 33'd0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        st_d    = shift_type;
                        shimm_d = shift_imm;
                        rot_d   = rotate_imm;
                        imm8_d  = imm8;
                        rm_d    = rm_val;
                        c_d     = c_in;
                        if (i_bit) begin
                            sel_d   = SEL_ROT;
                            state_d = SHIFT;
                        end else if (!reg_shift) begin
                            sel_d   = SEL_IMM;
                            state_d = SHIFT;
                        end else begin
                            sel_d     = SEL_REG;
                            state_d   = RS_WAIT;
                            rs_addr_d = rs_idx;
                            rd_en_d   = 1'b1;
                            cnt_d     = LAT_INIT;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                RS_WAIT: begin
                    cnt_d = cnt_q - 2'd1;
                    // Counter reaches zero on this edge: read data is valid now.
                    if (cnt_q <= 2'd1) begin
                        cnt_d   = 2'd0;
                        amt_d   = rs_data[7:0];
                        state_d = SHIFT;
                    end else begin
                        state_d = RS_WAIT;
                    end
                end
                SHIFT: begin
                    if (sel_q == SEL_ROT) begin
                        res_s = barrel(2'b11, {3'b000, rot_q, 1'b0}, 1'b0, {24'h000000, imm8_q}, c_q);
                    end else if (sel_q == SEL_IMM) begin
                        res_s = barrel(st_q, imm_amt_s, imm_rrx_s, rm_q, c_q);
                    end else begin
                        res_s = barrel(st_q, amt_q, 1'b0, rm_q, c_q);
                    end
                    op_d    = res_s[31:0];
                    carry_d = res_s[32];
                    state_d = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        req_ready_d = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            sel_q       <= 2'b00;
            st_q        <= 2'b00;
            shimm_q     <= 5'd0;
            rot_q       <= 4'd0;
            imm8_q      <= 8'd0;
            rm_q        <= 32'd0;
            c_q         <= 1'b0;
            amt_q       <= 8'd0;
            rs_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            req_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            op_q        <= 32'd0;
            carry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            st_q        <= st_d;
            shimm_q     <= shimm_d;
            rot_q       <= rot_d;
            imm8_q      <= imm8_d;
            rm_q        <= rm_d;
            c_q         <= c_d;
            amt_q       <= amt_d;
            rs_addr_q   <= rs_addr_d;
            rd_en_q     <= rd_en_d;
            req_ready_q <= req_ready_d;
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign out_valid       = out_valid_q;
    assign rs_addr         = rs_addr_q;
    assign rs_rd_en        = rd_en_q;
    assign shifter_sel     = sel_q;
    assign shifter_operand = op_q;
    assign shifter_carry   = carry_q;
endmodule

// File: tb/tb_shifter_op_ctrl.sv
// Self-checking bench for shifter_op_ctrl: vector table through a scoreboard,
// then flush, backpressure and mid-operation reset sequences.
module tb_shifter_op_ctrl;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n, flush, req_valid, req_ready, i_bit, reg_shift, c_in;
    logic [1:0]  shift_type, shifter_sel;
    logic [4:0]  shift_imm;
    logic [3:0]  rotate_imm, rs_idx, rs_addr;
    logic [7:0]  imm8;
    logic [31:0] rm_val, rs_data, shifter_operand;
    logic        rs_rd_en, out_valid, out_ready, shifter_carry;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ib, rsh;
        logic [1:0]  st;
        logic [4:0]  shimm;
        logic [3:0]  rot;
        logic [7:0]  imm8;
        logic [3:0]  rsi;
        logic [31:0] rm;
        logic        c;
        logic [31:0] rs;
        logic [31:0] eop;
        logic        ec;
        logic [1:0]  esel;
        int          hold;
    } rec_t;

    typedef struct {
        logic [31:0] op;
        logic        c;
        logic [1:0]  sel;
    } exp_t;

    rec_t tbl[$];
    exp_t sb[$];

    shifter_op_ctrl #(.RF_ADDR_W(4), .RS_READ_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .i_bit(i_bit), .reg_shift(reg_shift), .shift_type(shift_type), .shift_imm(shift_imm),
        .rotate_imm(rotate_imm), .imm8(imm8), .rs_idx(rs_idx), .rm_val(rm_val), .c_in(c_in),
        .rs_addr(rs_addr), .rs_rd_en(rs_rd_en), .rs_data(rs_data), .shifter_sel(shifter_sel),
        .out_valid(out_valid), .out_ready(out_ready), .shifter_operand(shifter_operand),
        .shifter_carry(shifter_carry)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic ib, input logic rsh, input logic [1:0] st,
                                input logic [4:0] shimm, input logic [3:0] rot, input logic [7:0] i8,
                                input logic [3:0] rsi, input logic [31:0] rm, input logic c,
                                input logic [31:0] rs, input logic [31:0] eop, input logic ec,
                                input logic [1:0] esel, input int hold);
        rec_t r;
        r.ib = ib; r.rsh = rsh; r.st = st; r.shimm = shimm; r.rot = rot; r.imm8 = i8;
        r.rsi = rsi; r.rm = rm; r.c = c; r.rs = rs; r.eop = eop; r.ec = ec; r.esel = esel;
        r.hold = hold;
        return r;
    endfunction

    task automatic apply(input rec_t r);
        i_bit = r.ib; reg_shift = r.rsh; shift_type = r.st; shift_imm = r.shimm;
        rotate_imm = r.rot; imm8 = r.imm8; rs_idx = r.rsi; rm_val = r.rm; c_in = r.c;
    endtask

    task automatic scramble();
        i_bit = 1'($urandom); reg_shift = 1'($urandom); shift_type = 2'($urandom);
        shift_imm = 5'($urandom); rotate_imm = 4'($urandom); imm8 = 8'($urandom);
        rs_idx = 4'($urandom); rm_val = $urandom; c_in = 1'($urandom);
    endtask

    // One full transaction: accept, emulate the RF read port, wait for the result, hand it off.
    task automatic run_op(input rec_t r);
        exp_t e;
        int   k, exp_lat;
        bit   rd_ok, is_reg;
        is_reg = !r.ib && r.rsh;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        apply(r);
        req_valid = 1'b1;
        @(posedge clk);
        e.op = r.eop; e.c = r.ec; e.sel = r.esel;
        sb.push_back(e);
        exp_lat = is_reg ? 2 + LAT : 2;
        #1 req_valid = 1'b0;
        scramble();
        k = 1;
        rd_ok = 1'b1;
        forever begin
            @(negedge clk);
            rs_data = (is_reg && k == LAT) ? r.rs : 32'hDEADBEEF;
            if (rs_rd_en !== ((is_reg && k == 1) ? 1'b1 : 1'b0)) rd_ok = 1'b0;
            if (is_reg && k == 1 && rs_addr !== r.rsi) rd_ok = 1'b0;
            if (out_valid === 1'b1 || k >= 20) break;
            @(posedge clk);
            k++;
        end
        rs_data = 32'hDEADBEEF;
        chk("rd_strobe", {31'd0, rd_ok}, 32'd1);
        chk("latency", k, exp_lat);
        e = sb.pop_front();
        chk("operand", shifter_operand, e.op);
        chk("carry", {31'd0, shifter_carry}, {31'd0, e.c});
        chk("sel", {30'd0, shifter_sel}, {30'd0, e.sel});
        for (int h = 0; h < r.hold; h++) begin
            req_valid = 1'b1;
            scramble();
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_op", shifter_operand, e.op);
            chk("hold_carry", {31'd0, shifter_carry}, {31'd0, e.c});
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("valid_drop", {31'd0, out_valid}, 32'd0);
        chk("ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        rs_data = 32'hDEADBEEF;
        scramble();

        //     ib rsh st    sh    rot   imm8   rsi   rm             c     rs          eop            ec    sel   hold
        tbl.push_back(mk(1'b1, 1'b0, 2'd0, 5'd0, 4'd4,  8'hFF, 4'd0, 32'h0,        1'b0, 32'h0,   32'hFF000000, 1'b1, 2'd0, 5));
        tbl.push_back(mk(1'b1, 1'b0, 2'd0, 5'd0, 4'd0,  8'h3F, 4'd0, 32'h0,        1'b1, 32'h0,   32'h0000003F, 1'b1, 2'd0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 2'd0, 5'd0, 4'd1,  8'h01, 4'd0, 32'h0,        1'b0, 32'h0,   32'h40000000, 1'b0, 2'd0, 0));
        tbl.push_back(mk(1'b1, 1'b1, 2'd0, 5'd0, 4'd15, 8'h80, 4'd0, 32'h0,        1'b0, 32'h0,   32'h00000200, 1'b0, 2'd0, 0));
        tbl.push_back(mk(1'b0, 1'b0, 2'd1, 5'd0, 4'd0,  8'h00, 4'd0, 32'h80000001, 1'b0, 32'h0,   32'h00000000, 1'b1, 2'd1, 0));
        tbl.push_back(mk(1'b0, 1'b0, 2'd3, 5'd0, 4'd0,  8'h00, 4'd0, 32'h80000001, 1'b1, 32'h0,   32'hC0000000, 1'b1, 2'd1, 0));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 5'd0, 4'd0,  8'h00, 4'd0, 32'h12345678, 1'b1, 32'h0,   32'h12345678, 1'b1, 2'd1, 0));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 5'd4, 4'd0,  8'h00, 4'd0, 32'hF0000001, 1'b0, 32'h0,   32'h00000010, 1'b1, 2'd1, 0));
        tbl.push_back(mk(1'b0, 1'b0, 2'd2, 5'd0, 4'd0,  8'h00, 4'd0, 32'h80000000, 1'b0, 32'h0,   32'hFFFFFFFF, 1'b1, 2'd1, 0));
        tbl.push_back(mk(1'b0, 1'b0, 2'd2, 5'd4, 4'd0,  8'h00, 4'd0, 32'h8000000F, 1'b0, 32'h0,   32'hF8000000, 1'b1, 2'd1, 0));
        tbl.push_back(mk(1'b0, 1'b0, 2'd1, 5'd1, 4'd0,  8'h00, 4'd0, 32'h00000003, 1'b0, 32'h0,   32'h00000001, 1'b1, 2'd1, 0));
        tbl.push_back(mk(1'b0, 1'b0, 2'd3, 5'd8, 4'd0,  8'h00, 4'd0, 32'h000000AB, 1'b0, 32'h0,   32'hAB000000, 1'b1, 2'd1, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 5'd0, 4'd0,  8'h00, 4'd5, 32'hFFFFFFFF, 1'b0, 32'h21,  32'h00000000, 1'b0, 2'd2, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 5'd0, 4'd0,  8'h00, 4'd9, 32'hFFFFFFFF, 1'b0, 32'h120, 32'h00000000, 1'b1, 2'd2, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd3, 5'd0, 4'd0,  8'h00, 4'd3, 32'h0000ABCD, 1'b1, 32'h100, 32'h0000ABCD, 1'b1, 2'd2, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd1, 5'd0, 4'd0,  8'h00, 4'd7, 32'h000000F8, 1'b0, 32'h4,   32'h0000000F, 1'b1, 2'd2, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd3, 5'd0, 4'd0,  8'h00, 4'd1, 32'h80000000, 1'b0, 32'h20,  32'h80000000, 1'b1, 2'd2, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd1, 5'd0, 4'd0,  8'h00, 4'd2, 32'h80000000, 1'b0, 32'h20,  32'h00000000, 1'b1, 2'd2, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd3, 5'd0, 4'd0,  8'h00, 4'd15, 32'h0000000F, 1'b0, 32'h24, 32'hF0000000, 1'b1, 2'd2, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 5'd0, 4'd0,  8'h00, 4'd6, 32'h80000000, 1'b0, 32'h1,   32'h00000000, 1'b1, 2'd2, 0));

        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rd_en", {31'd0, rs_rd_en}, 32'd0);
        chk("rst_operand", shifter_operand, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_op(tbl[i]);

        // Flush in DONE together with out_ready; operand must stay at its last value.
        @(negedge clk);
        apply(tbl[2]);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        scramble();
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("fl_done_reach", {31'd0, out_valid}, 32'd1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("fl_done_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_done_ready", {31'd0, req_ready}, 32'd1);
        chk("fl_done_op", shifter_operand, 32'h40000000);

        // Flush while waiting for Rs: no result may appear afterwards.
        @(negedge clk);
        apply(tbl[12]);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        scramble();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("fl_rw_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_rw_ready", {31'd0, req_ready}, 32'd1);
        chk("fl_rw_op", shifter_operand, 32'h40000000);
        repeat (6) @(negedge clk);
        chk("fl_rw_quiet", {30'd0, out_valid, rs_rd_en}, 32'd0);

        // Reset while in SHIFT.
        @(negedge clk);
        apply(tbl[7]);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_rd", {31'd0, rs_rd_en}, 32'd0);
        chk("mid_rst_addr", {28'd0, rs_addr}, 32'd0);
        chk("mid_rst_sel", {30'd0, shifter_sel}, 32'd0);
        chk("mid_rst_op", shifter_operand, 32'd0);
        chk("mid_rst_carry", {31'd0, shifter_carry}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(mk(1'b0, 1'b1, 2'd2, 5'd0, 4'd0, 8'h00, 4'd11, 32'h80000000, 1'b0, 32'h40,
                  32'hFFFFFFFF, 1'b1, 2'd2, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shifter_op_ctrl.md
Name: shifter_op_ctrl

Overview:
- Sequences generation of the ARM data-processing second operand (shifter_operand) and shifter carry-out for the execute stage.
- Accepts decoded operand-2 fields over a valid/ready handshake and drives the shifter operand-select code: 00 = rotate immediate, 01 = immediate shift, 10 = register shift.
- For register-specified shifts, fetches Rs from the register file through a dedicated read port with configurable latency.
- Presents the result on a valid/ready output.

Parameters:
RF_ADDR_W, 4, register file address width
RS_READ_LAT, 1, register file read latency in cycles; legal range 1..3

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort; returns block to IDLE
req_valid  input  1  operand request valid
req_ready  output  1  block can accept a request
i_bit  input  1  instruction bit 25: immediate operand form
reg_shift  input  1  instruction bit 4: register-specified shift (ignored when i_bit=1)
shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
shift_imm  input  5  immediate shift amount
rotate_imm  input  4  immediate rotate field
imm8  input  8  immediate byte
rs_idx  input  RF_ADDR_W  Rs register index
rm_val  input  32  Rm operand value, sampled at accept
c_in  input  1  CPSR C flag, sampled at accept
rs_addr  output  RF_ADDR_W  register file read address
rs_rd_en  output  1  register file read strobe, 1 cycle
rs_data  input  32  register file read data, valid RS_READ_LAT cycles after rs_rd_en
shifter_sel  output  2  operand-select code for the current operation
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
shifter_operand  output  32  result
shifter_carry  output  1  shifter carry-out

Behaviour:
- States: IDLE, RS_WAIT, SHIFT, DONE.
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1; out_valid=0; rs_rd_en=0.
  - rs_addr=0; shifter_sel=00; shifter_operand=0; shifter_carry=0.
  - Latency counter = 0.
- IDLE:
  - req_ready=1 only in IDLE. Acceptance happens on an edge with req_valid=1 in IDLE; all request fields, rm_val and c_in are registered on that edge.
  - shifter_sel is set at accept: 00 if i_bit=1, else 01 if reg_shift=0, else 10.
  - shifter_sel holds until the next accept.
  - Register shift: go to RS_WAIT. At the accept edge, drive rs_addr=rs_idx and rs_rd_en=1 for exactly one cycle; load counter=RS_READ_LAT.
  - Otherwise: go to SHIFT.
- RS_WAIT:
  - Counter decrements each cycle.
  - When it reaches 0, capture rs_data[7:0] as the shift amount and go to SHIFT.
- SHIFT:
  - Compute and register shifter_operand and shifter_carry (single cycle); go to DONE.
- DONE:
  - out_valid=1; result is held stable until out_ready=1.
  - On an edge with out_ready=1: out_valid falls and state goes to IDLE. The next accept is possible on the following edge; there is no same-edge overlap.
- Latency from accept edge E to out_valid high:
  - immediate and imm-shift forms: edge E+2;
  - register shift: edge E+2+RS_READ_LAT.
- Arithmetic, rotate immediate:
  - result = imm8 zero-extended, rotated right by 2*rotate_imm.
  - carry = c_in if rotate_imm==0, else result[31].
- Arithmetic, immediate shift (n = shift_imm):
  - LSL: n=0 gives rm, carry c_in; else rm<<n, carry rm[32-n].
  - LSR: n=0 means 32, giving 0 with carry rm[31]; else rm>>n, carry rm[n-1].
  - ASR: n=0 means 32, giving all bits = rm[31] and carry rm[31]; else arithmetic shift, carry rm[n-1].
  - ROR: n=0 means RRX, giving {c_in, rm[31:1]} with carry rm[0]; else rotate, carry rm[n-1].
- Arithmetic, register shift (n = Rs[7:0]):
  - n=0 (any type): result rm, carry c_in.
  - LSL: n<32 gives rm<<n, carry rm[32-n]; n=32 gives 0, carry rm[0]; n>32 gives 0, carry 0.
  - LSR: n<32 gives rm>>n, carry rm[n-1]; n=32 gives 0, carry rm[31]; n>32 gives 0, carry 0.
  - ASR: n>=32 gives all bits = rm[31], carry rm[31].
  - ROR: n[4:0]=0 with n!=0 gives rm, carry rm[31]; else rotate by n[4:0], carry rm[n[4:0]-1].
- flush:
  - From any state, next state is IDLE; out_valid=0; rs_rd_en=0; counter=0.
  - flush has priority over accept and completion on the same edge.
  - shifter_operand and shifter_carry keep their last values.
- Reset mid-operation: immediate return to reset values; no output handshake completes.
- Input changes while not in IDLE are ignored.

Test Plan:
- Rotate immediate: imm8=0xFF, rotate_imm=4, c_in=0 -> shifter_sel=00; operand=0xFF000000, carry=1; out_valid at E+2.
- Imm shift: rm=0x80000001, LSR, shift_imm=0 -> operand=0, carry=1. Then ROR with shift_imm=0 and c_in=1 (RRX) -> operand=0xC0000000, carry=1.
- Reg shift, RS_READ_LAT=2:
  - rs_data=0x00000021, LSL, rm=0xFFFFFFFF -> rs_rd_en pulses 1 cycle with rs_addr=rs_idx; operand=0, carry=0; out_valid at E+4; sel=10.
  - Repeat with rs_data=0x120 (n=0x20) -> operand=0, carry=rm[0]=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, operand and carry stable; req_ready=0 throughout; req_valid is ignored.
- flush asserted in RS_WAIT (and separately in DONE with out_ready=1 on the same edge) -> IDLE next cycle; out_valid=0; req_ready=1.
- rst_n low mid-SHIFT, released -> all outputs at reset values; a fresh ASR with rm=0x80000000 and Rs=0x40 yields 0xFFFFFFFF, carry=1.
